mem_wb_pipe: RTL

- Parametrised MEM->WB pipeline register for the multi-issue core.
- Carries LANES register-write slots plus one HI/LO write per bundle from the memory stage to writeback.
- Replaces the fixed single-lane latch with a valid/ready handshake, a 2-entry skid buffer, flush, intra-bundle write-conflict resolution and a retired-bundle counter.

---
 rtl/mem_wb_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM->WB pipeline register with valid/ready handshake, 2-entry
//               skid buffer, flush, intra-bundle write-conflict resolution and
//               a retired-bundle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ADDR_W-1:0]   mem_wd,
    input  logic [LANES-1:0]          mem_wreg,
    input  logic [LANES*DATA_W-1:0]   mem_wdata,
    input  logic                      mem_whilo,
    input  logic [DATA_W-1:0]         mem_hi,
    input  logic [DATA_W-1:0]         mem_lo,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ADDR_W-1:0]   wb_wd,
    output logic [LANES-1:0]          wb_wreg,
    output logic [LANES*DATA_W-1:0]   wb_wdata,
    output logic                      wb_whilo,
    output logic [DATA_W-1:0]         wb_hi,
    output logic [DATA_W-1:0]         wb_lo,
    output logic [CNT_W-1:0]          retire_cnt
);

    logic                    r_main_valid;
    logic [LANES*ADDR_W-1:0] r_main_wd;
    logic [LANES-1:0]        r_main_wreg;
    logic [LANES*DATA_W-1:0] r_main_wdata;
    logic                    r_main_whilo;
    logic [DATA_W-1:0]       r_main_hi;
    logic [DATA_W-1:0]       r_main_lo;

    logic                    r_skid_valid;
    logic [LANES*ADDR_W-1:0] r_skid_wd;
    logic [LANES-1:0]        r_skid_wreg;
    logic [LANES*DATA_W-1:0] r_skid_wdata;
    logic                    r_skid_whilo;
    logic [DATA_W-1:0]       r_skid_hi;
    logic [DATA_W-1:0]       r_skid_lo;

    logic [CNT_W-1:0]        r_cnt;

    logic                    w_accept;
    logic                    w_consume;
    logic [LANES-1:0]        w_res_wreg;

    assign in_ready  = !r_skid_valid && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_main_valid && out_ready;

    // A lane loses its write when any higher lane targets the same register.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic w_hit;
            always_comb begin
                w_hit = 1'b0;
                for (int j = i + 1; j < LANES; j++) begin
                    if (mem_wreg[j] &&
                        (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
                        w_hit = 1'b1;
                    end
                end
            end
            assign w_res_wreg[i] = mem_wreg[i] && !w_hit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_wd    <= '0;
            r_main_wreg  <= '0;
            r_main_wdata <= '0;
            r_main_whilo <= 1'b0;
            r_main_hi    <= '0;
            r_main_lo    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_wd    <= '0;
            r_skid_wreg  <= '0;
            r_skid_wdata <= '0;
            r_skid_whilo <= 1'b0;
            r_skid_hi    <= '0;
            r_skid_lo    <= '0;
            r_cnt        <= '0;
        end else begin
            // A consume coinciding with flush still reached writeback.
            if (w_consume) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (flush) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_consume && r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_wd    <= r_skid_wd;
                r_main_wreg  <= r_skid_wreg;
                r_main_wdata <= r_skid_wdata;
                r_main_whilo <= r_skid_whilo;
                r_main_hi    <= r_skid_hi;
                r_main_lo    <= r_skid_lo;
                r_skid_valid <= 1'b0;
            end else if (w_accept && (!r_main_valid || w_consume)) begin
                r_main_valid <= 1'b1;
                r_main_wd    <= mem_wd;
                r_main_wreg  <= w_res_wreg;
                r_main_wdata <= mem_wdata;
                r_main_whilo <= mem_whilo;
                r_main_hi    <= mem_hi;
                r_main_lo    <= mem_lo;
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_wd    <= mem_wd;
                r_skid_wreg  <= w_res_wreg;
                r_skid_wdata <= mem_wdata;
                r_skid_whilo <= mem_whilo;
                r_skid_hi    <= mem_hi;
                r_skid_lo    <= mem_lo;
            end else if (w_consume) begin
                r_main_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_main_valid;
    assign wb_wd      = r_main_wd;
    assign wb_wreg    = r_main_wreg & {LANES{r_main_valid}};
    assign wb_wdata   = r_main_wdata;
    assign wb_whilo   = r_main_whilo && r_main_valid;
    assign wb_hi      = r_main_hi;
    assign wb_lo      = r_main_lo;
    assign retire_cnt = r_cnt;

endmodule
`default_nettype wire
